output_commit_buffer: RTL and testbench

OUTPUT_COMMIT_BUFFER -- requirements
Module: output_commit_buffer

---
 rtl/output_commit_buffer_pkg.sv | 17 +
 rtl/output_commit_buffer_shadow_edit_reg.sv | 55 +++++
 rtl/output_commit_buffer.sv | 113 +++++++++++
 tb/tb_output_commit_buffer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/output_commit_buffer_pkg.sv
// Shared control-path types for the output commit buffer.
//   pub_state_e : publication FSM state (IDLE = nothing outstanding,
//                 VALID = out_buf holds an unaccepted word)
//   load_src_e  : source select for loads/edits (val replicated or in_data)
package output_commit_buffer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } pub_state_e;

  typedef enum logic {
    SRC_VAL = 1'b0,
    SRC_IN  = 1'b1
  } load_src_e;

endpackage

// File: rtl/output_commit_buffer_shadow_edit_reg.sv
// shadow_edit_reg: working copy of the output word. It takes whole-word loads
// and single-bit edits. Both use the same data rule per bit:
// mux_data ? in_data[i] : val.
//   clk, reset            : clock, async active-high reset (shadow -> 0)
//   addr/do_write/en_edit : single-bit edit request (en_edit & do_write)
//   en_load_input         : write every bit
//   val/in_data/mux_data  : data source
//   shadow                : current shadow word
//   edit_hit              : accepted in-range edit this cycle
//   edit_oob              : edit requested with addr >= WIDTH (ignored)
module shadow_edit_reg
  import output_commit_buffer_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              do_write,
  input  logic              val,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              en_edit,
  input  logic              en_load_input,
  input  logic              mux_data,
  output logic [WIDTH-1:0]  shadow,
  output logic              edit_hit,
  output logic              edit_oob
);

  logic [31:0]      addr_ext;
  logic             edit_req;
  logic             src_in;
  logic [WIDTH-1:0] wr_mask;
  logic [WIDTH-1:0] wr_data;

  assign addr_ext = 32'(addr);
  assign edit_req = en_edit & do_write;
  assign edit_hit = edit_req & (addr_ext <  32'(WIDTH));
  assign edit_oob = edit_req & (addr_ext >= 32'(WIDTH));
  assign src_in   = (load_src_e'(mux_data) == SRC_IN);
  assign wr_data  = src_in ? in_data : {WIDTH{val}};

  // A load and an edit in the same cycle OR their enables. The data rule
  // does not change, so the edit adds nothing beyond the load.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign wr_mask[i] = en_load_input | (edit_hit & (addr_ext == 32'(i)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) shadow <= '0;
    else       shadow <= (shadow & ~wr_mask) | (wr_data & wr_mask);
  end

endmodule

// File: rtl/output_commit_buffer.sv
// output_commit_buffer: collects loads and bit edits in a shadow register and
// publishes the shadow to out_buf on commit, using a valid/ready handshake.
// A commit that arrives while a word is outstanding is held as pending. On
// the next handshake the current shadow is republished.
//   clk, reset    : clock, async active-high reset
//   addr, do_write, val, in_data, en_edit, en_load_input, mux_data
//                 : shadow load/edit controls (see shadow_edit_reg)
//   commit        : request to publish the shadow
//   out_ready     : downstream accepts out_buf
//   out_buf       : published word, held stable while unaccepted
//   out_valid     : out_buf holds an unaccepted publication
//   edit_count    : accepted edits since last publication (saturating)
//   err_addr      : one-cycle pulse after an out-of-range edit
module output_commit_buffer
  import output_commit_buffer_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = $clog2(WIDTH),
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              do_write,
  input  logic              val,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              en_edit,
  input  logic              en_load_input,
  input  logic              mux_data,
  input  logic              commit,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_buf,
  output logic              out_valid,
  output logic [CNT_W-1:0]  edit_count,
  output logic              err_addr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pub_state_e       state;
  logic             pending;
  logic             publish;
  logic             edit_hit;
  logic             edit_oob;
  logic [WIDTH-1:0] shadow;

  shadow_edit_reg #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_shadow (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .do_write     (do_write),
    .val          (val),
    .in_data      (in_data),
    .en_edit      (en_edit),
    .en_load_input(en_load_input),
    .mux_data     (mux_data),
    .shadow       (shadow),
    .edit_hit     (edit_hit),
    .edit_oob     (edit_oob)
  );

  // A publication happens in two cases. The first is a commit in IDLE. The
  // second is a handshake in VALID while a commit is pending or arrives in
  // the same cycle. out_buf samples the registered shadow, so that cycle's
  // own load/edit is left for the next publication.
  assign publish = (state == ST_IDLE) ? commit
                                      : (out_ready & (pending | commit));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      out_buf    <= '0;
      out_valid  <= 1'b0;
      pending    <= 1'b0;
      edit_count <= '0;
      err_addr   <= 1'b0;
    end else begin
      err_addr <= edit_oob;

      case (state)
        ST_IDLE: begin
          if (commit) begin
            out_buf   <= shadow;
            out_valid <= 1'b1;
            state     <= ST_VALID;
          end
        end
        ST_VALID: begin
          if (out_ready) begin
            pending <= 1'b0;
            if (pending | commit) begin
              out_buf <= shadow;
            end else begin
              out_valid <= 1'b0;
              state     <= ST_IDLE;
            end
          end else if (commit) begin
            pending <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // The count clears on a publication. An edit accepted in that same
      // cycle belongs to the next word, so it counts as 1.
      if (publish)
        edit_count <= edit_hit ? CNT_W'(1) : '0;
      else if (edit_hit && edit_count != CNT_MAX)
        edit_count <= edit_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_output_commit_buffer.sv
module tb_output_commit_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  addr;
  logic        do_write, val, en_edit, en_load_input, mux_data, commit, out_ready;
  logic [31:0] in_data;

  logic [31:0] a_out_buf;
  logic        a_out_valid, a_err_addr;
  logic [3:0]  a_edit_count;

  logic [23:0] b_out_buf;
  logic        b_out_valid, b_err_addr;
  logic [1:0]  b_edit_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  output_commit_buffer #(.WIDTH(32), .CNT_W(4)) u_a (
    .clk(clk), .reset(reset), .addr(addr), .do_write(do_write), .val(val),
    .in_data(in_data), .en_edit(en_edit), .en_load_input(en_load_input),
    .mux_data(mux_data), .commit(commit), .out_ready(out_ready),
    .out_buf(a_out_buf), .out_valid(a_out_valid),
    .edit_count(a_edit_count), .err_addr(a_err_addr)
  );

  output_commit_buffer #(.WIDTH(24), .CNT_W(2)) u_b (
    .clk(clk), .reset(reset), .addr(addr), .do_write(do_write), .val(val),
    .in_data(in_data[23:0]), .en_edit(en_edit), .en_load_input(en_load_input),
    .mux_data(mux_data), .commit(commit), .out_ready(out_ready),
    .out_buf(b_out_buf), .out_valid(b_out_valid),
    .edit_count(b_edit_count), .err_addr(b_err_addr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    addr = '0; do_write = 0; val = 0; en_edit = 0; en_load_input = 0;
    mux_data = 0; commit = 0; out_ready = 0; in_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  task automatic edit(input logic [4:0] a, input logic v);
    en_edit = 1; do_write = 1; mux_data = 0; addr = a; val = v;
  endtask

  task automatic no_edit();
    en_edit = 0; do_write = 0;
  endtask

  initial begin
    // Reset values
    idle_inputs();
    reset = 1;
    tick();
    chk("rst_out_buf", 64'(a_out_buf), 0);
    chk("rst_out_valid", 64'(a_out_valid), 0);
    chk("rst_edit_count", 64'(a_edit_count), 0);
    chk("rst_err_addr", 64'(a_err_addr), 0);
    reset = 0;

    // Whole-word load from in_data, commit next cycle
    en_load_input = 1; mux_data = 1; in_data = 32'hA5A5_0F0F;
    tick();
    en_load_input = 0; commit = 1;
    tick();
    commit = 0;
    chk("load_out_buf", 64'(a_out_buf), 64'hA5A5_0F0F);
    chk("load_out_valid", 64'(a_out_valid), 1);
    chk("load_edit_count", 64'(a_edit_count), 0);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("load_hs_valid", 64'(a_out_valid), 0);

    // Bit edits on a zeroed shadow
    do_reset();
    edit(5'd0, 1'b1);
    tick();
    chk("edit_cnt1", 64'(a_edit_count), 1);
    edit(5'd31, 1'b1);
    tick();
    chk("edit_cnt2", 64'(a_edit_count), 2);
    no_edit(); commit = 1;
    tick();
    commit = 0;
    chk("edit_out_buf", 64'(a_out_buf), 64'h8000_0001);
    chk("edit_out_valid", 64'(a_out_valid), 1);
    chk("edit_cnt_clr", 64'(a_edit_count), 0);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("edit_hs_valid", 64'(a_out_valid), 0);

    // Pending commit while stalled
    commit = 1;
    tick();
    commit = 0;
    edit(5'd4, 1'b1);
    tick();
    no_edit(); commit = 1;
    tick();
    commit = 0;
    chk("stall_out_buf", 64'(a_out_buf), 64'h8000_0001);
    chk("stall_valid", 64'(a_out_valid), 1);
    chk("stall_cnt", 64'(a_edit_count), 1);
    tick();
    chk("stall_hold_buf", 64'(a_out_buf), 64'h8000_0001);
    out_ready = 1;
    tick();
    chk("pend_out_buf", 64'(a_out_buf), 64'h8000_0011);
    chk("pend_valid", 64'(a_out_valid), 1);
    chk("pend_cnt", 64'(a_edit_count), 0);
    tick();
    out_ready = 0;
    chk("pend_done_valid", 64'(a_out_valid), 0);

    // Commit together with out_ready in VALID republishes immediately
    commit = 1;
    tick();
    commit = 0;
    edit(5'd8, 1'b1);
    tick();
    no_edit(); commit = 1; out_ready = 1;
    tick();
    commit = 0;
    chk("repub_out_buf", 64'(a_out_buf), 64'h8000_0111);
    chk("repub_valid", 64'(a_out_valid), 1);
    tick();
    out_ready = 0;
    chk("repub_done_valid", 64'(a_out_valid), 0);

    // Narrow instance: out-of-range edit
    do_reset();
    edit(5'd30, 1'b1);
    tick();
    no_edit();
    chk("oob_err_pulse", 64'(b_err_addr), 1);
    chk("oob_cnt", 64'(b_edit_count), 0);
    tick();
    chk("oob_err_clear", 64'(b_err_addr), 0);
    commit = 1;
    tick();
    commit = 0;
    chk("oob_shadow", 64'(b_out_buf), 0);
    out_ready = 1;
    tick();
    out_ready = 0;

    // Narrow instance: saturating count, and a commit with a same-cycle edit
    for (int i = 0; i < 5; i++) begin
      edit(5'(i), 1'b1);
      tick();
    end
    chk("sat_cnt", 64'(b_edit_count), 3);
    edit(5'd5, 1'b1); commit = 1;
    tick();
    no_edit(); commit = 0;
    chk("sat_pub_buf", 64'(b_out_buf), 64'h00_001F);
    chk("sat_pub_cnt", 64'(b_edit_count), 1);
    out_ready = 1;
    tick();
    out_ready = 0; commit = 1;
    tick();
    commit = 0;
    chk("late_edit_buf", 64'(b_out_buf), 64'h00_003F);
    chk("late_edit_valid", 64'(b_out_valid), 1);

    // Asynchronous reset while a word is outstanding
    chk("pre_rst_valid", 64'(a_out_valid), 1);
    #2;
    reset = 1;
    #1;
    chk("async_a_buf", 64'(a_out_buf), 0);
    chk("async_a_valid", 64'(a_out_valid), 0);
    chk("async_b_valid", 64'(b_out_valid), 0);
    out_ready = 1;
    tick();
    reset = 0;
    tick();
    chk("post_rst_valid", 64'(a_out_valid), 0);
    out_ready = 0; commit = 1;
    tick();
    commit = 0;
    chk("post_rst_buf", 64'(a_out_buf), 0);
    chk("post_rst_pub", 64'(a_out_valid), 1);
    out_ready = 1;
    tick();
    out_ready = 0;

    // Replicated-val load leaves edit_count alone; mux_data=1 edit takes in_data bit
    en_load_input = 1; mux_data = 0; val = 1;
    tick();
    en_load_input = 0;
    chk("valload_cnt", 64'(a_edit_count), 0);
    en_edit = 1; do_write = 1; mux_data = 1; addr = 5'd2; in_data = 32'h0000_0000;
    tick();
    no_edit(); mux_data = 0;
    chk("muxedit_cnt", 64'(a_edit_count), 1);
    commit = 1;
    tick();
    commit = 0;
    chk("muxedit_buf", 64'(a_out_buf), 64'hFFFF_FFFB);

    // Load and edit in the same cycle with do_write low: the edit is ignored
    out_ready = 1;
    tick();
    out_ready = 0;
    en_edit = 1; do_write = 0; en_load_input = 1; mux_data = 1; in_data = 32'h1234_5678;
    tick();
    en_edit = 0; en_load_input = 0;
    chk("nowrite_cnt", 64'(a_edit_count), 0);
    commit = 1;
    tick();
    commit = 0;
    chk("nowrite_buf", 64'(a_out_buf), 64'h1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
